window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning image width in pixels (legal 3..1024).
REQ-002 SHALL have parameter IMG_H, default 64, meaning image height in pixels (legal 3..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port px_in  input  8  raster-order pixel, row-major, top-left first.
REQ-006 SHALL have port px_in_valid  input  1  qualifies px_in; pixel is accepted on a cycle where it is high.
REQ-007 SHALL have port px_in_sof  input  1  start-of-frame; meaningful only with px_in_valid.
REQ-008 SHALL have ports px_1..px_9  output  8 each  3x3 window, raster order: px_1 top-left, px_5 centre, px_9 bottom-right.
REQ-009 SHALL have port win_valid  output  1  px_1..px_9 hold a complete window.

Function
REQ-010 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters giving the position of the pixel being accepted.
REQ-011 SHALL advance col by 1 per accepted pixel; at IMG_W-1 it wraps to 0 and row increments; at (IMG_W-1, IMG_H-1) both wrap to 0.
REQ-012 SHALL treat an accepted pixel with px_in_sof=1 as position (0,0) regardless of counter state; the next accepted pixel is (1,0).
REQ-013 SHALL hold two line buffers of IMG_W bytes storing rows r-1 and r-2, written/read at index col on each accepted pixel.
REQ-014 SHALL hold a 3x3 shift register window shifted left by one column per accepted pixel, new column = {linebuf2[col], linebuf1[col], px_in}.
REQ-015 SHALL assert win_valid for exactly one cycle, the cycle after accepting pixel (c,r) with c>=2 and r>=2; the window then covers rows r-2..r, cols c-2..c.
REQ-016 SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows per frame; no border windows, no padding.
REQ-017 SHALL neither shift nor alter state when px_in_valid=0; px_1..px_9 hold their values and win_valid is 0.
REQ-018 SHALL have no backpressure; downstream must accept every window on the win_valid cycle.
REQ-019 SHALL never let columns from the end of row r-1 appear in a valid window of row r (wrap gated by REQ-015 c>=2).
REQ-020 SHALL never form a valid window using line-buffer data from a previous frame (gated by r>=2 after sof).

Reset
REQ-021 SHALL, on reset low, asynchronously clear col, row, window registers, px_1..px_9 to 0 and win_valid to 0.
REQ-022 SHALL not require line-buffer contents to be cleared by reset.
REQ-023 SHALL, after reset release, treat the first accepted pixel as (0,0) whether or not px_in_sof is high.

Configuration
REQ-024 SHALL, when macro WINGEN_EOF_EN is defined, add output win_eof (1 bit, reset 0) that is high together with win_valid only for the last window of the frame (centre at (IMG_W-2, IMG_H-2)).
REQ-025 SHALL, when WINGEN_EOF_EN is undefined, have no win_eof port and otherwise identical behaviour.

Verification
REQ-026 IMG_W=IMG_H=4, pixels 0..15 continuous, sof on pixel 0 -> first win_valid cycle after pixel 10 with px_1..px_9 = 0,1,2,4,5,6,8,9,10; total 4 windows, last = 5,6,7,9,10,11,13,14,15.
REQ-027 Same stimulus with px_in_valid toggled 1,0,1,0 -> identical window values and count; win_valid only on cycles after accepted pixels.
REQ-028 IMG_W=5, IMG_H=3, pixels 0..14 -> windows centred at (1,1),(2,1),(3,1) only; no window mixing column 4 of row 1 with column 0 of row 2.
REQ-029 IMG_W=IMG_H=4, reset low after pixel 7, then frame 100..115 -> no win_valid before pixel 110; first window 100,101,102,104,105,106,108,109,110.
REQ-030 IMG_W=IMG_H=4, sof reasserted on pixel 6 of a frame, then 16 pixels -> counters restart; exactly 4 windows from the new frame, none mixing old data.
REQ-031 WINGEN_EOF_EN defined, IMG_W=IMG_H=4, two back-to-back frames -> win_eof high exactly twice, each coincident with the 4th win_valid of its frame.

Source files
------------

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
// Optional macro WINGEN_EOF_EN adds win_eof, flagging the last window of each frame.
module window_gen_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] px_in,
    input  logic       px_in_valid,
    input  logic       px_in_sof,
    output logic [7:0] px_1,
    output logic [7:0] px_2,
    output logic [7:0] px_3,
    output logic [7:0] px_4,
    output logic [7:0] px_5,
    output logic [7:0] px_6,
    output logic [7:0] px_7,
    output logic [7:0] px_8,
    output logic [7:0] px_9,
`ifdef WINGEN_EOF_EN
    output logic       win_eof,
`endif
    output logic       win_valid
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [7:0]    lb1_rd, lb2_rd;
    logic [7:0]    win [3][3];
    logic          win_edge;

    // sof forces the accepted pixel to (0,0) no matter where the counters are.
    always_comb begin
        cur_col  = px_in_sof ? '0 : col;
        cur_row  = px_in_sof ? '0 : row;
        lb1_rd   = lb1[cur_col];
        lb2_rd   = lb2[cur_col];
        win_edge = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
    end

    // lb1 holds the previous row, lb2 the one before; contents need no reset.
    always_ff @(posedge clk) begin
        if (px_in_valid) begin
            lb1[cur_col] <= px_in;
            lb2[cur_col] <= lb1_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
`ifdef WINGEN_EOF_EN
            win_eof   <= 1'b0;
`endif
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win_valid <= px_in_valid && win_edge;
`ifdef WINGEN_EOF_EN
            win_eof   <= px_in_valid && win_edge &&
                         (cur_col == COL_MAX) && (cur_row == ROW_MAX);
`endif
            if (px_in_valid) begin
                if (cur_col == COL_MAX) begin
                    col <= '0;
                    row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= px_in;
            end
        end
    end

    assign px_1 = win[0][0];
    assign px_2 = win[0][1];
    assign px_3 = win[0][2];
    assign px_4 = win[1][0];
    assign px_5 = win[1][1];
    assign px_6 = win[1][2];
    assign px_7 = win[2][0];
    assign px_8 = win[2][1];
    assign px_9 = win[2][2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomized scoreboard bench for window_gen_3x3 on a non-square 5x4 image.
module tb_window_gen_3x3;
    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] px_in = '0;
    logic       px_in_valid = 1'b0;
    logic       px_in_sof = 1'b0;
    logic [7:0] px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9;
    logic       win_valid;
    logic       win_eof_s;
`ifdef WINGEN_EOF_EN
    logic       win_eof;
    assign win_eof_s = win_eof;
`else
    assign win_eof_s = 1'b0;
`endif

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .px_in(px_in), .px_in_valid(px_in_valid),
        .px_in_sof(px_in_sof),
        .px_1(px_1), .px_2(px_2), .px_3(px_3), .px_4(px_4), .px_5(px_5),
        .px_6(px_6), .px_7(px_7), .px_8(px_8), .px_9(px_9),
`ifdef WINGEN_EOF_EN
        .win_eof(win_eof),
`endif
        .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard: {eof, px_1..px_9}
    logic [72:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_win = 0;

    // Reference model: the image as a 2-D array and the current raster position.
    logic [7:0] img [H][W];
    int m_c = 0;
    int m_r = 0;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] px, input logic sof);
        logic [72:0] e;
        if (sof) begin
            m_c = 0;
            m_r = 0;
        end
        img[m_r][m_c] = px;
        if (m_c >= 2 && m_r >= 2) begin
            e[72] = (m_c == W - 1) && (m_r == H - 1);
`ifndef WINGEN_EOF_EN
            e[72] = 1'b0;
`endif
            e[71:0] = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c],
                       img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c],
                       img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
            exp_q.push_back(e);
        end
        m_c++;
        if (m_c == W) begin
            m_c = 0;
            m_r = (m_r == H - 1) ? 0 : m_r + 1;
        end
    endtask

    task automatic drive(input logic [7:0] px, input logic vld, input logic sof);
        @(posedge clk);
        #1;
        px_in       = px;
        px_in_valid = vld;
        px_in_sof   = sof;
        if (vld) model_accept(px, sof);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive($urandom_range(0, 255), 1'b0, $urandom_range(0, 1));
    endtask

    task automatic do_reset();
        idle(2);
        reset = 1'b0;
        #1;
        check("reset_outputs",
              {win_eof_s, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9},
              73'd0);
        check("reset_win_valid", {72'd0, win_valid}, 73'd0);
        m_c = 0;
        m_r = 0;
        idle(1);
        reset = 1'b1;
    endtask

    // Monitor: pop and compare on every presented window.
    always @(negedge clk) begin
        if (reset && win_valid) begin
            n_win++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_window: got %h with empty queue",
                         {px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9});
            end else begin
                check("window",
                      {win_eof_s, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9},
                      exp_q.pop_front());
            end
        end else if (reset && win_eof_s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL eof_without_valid: got 1 expected 0");
        end
    end

    int base;

    initial begin
        #12;
        check("reset_initial", {win_eof_s, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9}, 73'd0);
        reset = 1'b1;

        // Continuous ramp frame, no sof: first pixel after reset is (0,0).
        base = n_win;
        for (int i = 0; i < W * H; i++) drive(8'(i), 1'b1, 1'b0);
        idle(3);
        check("frame1_count", 73'(n_win - base), 73'((W - 2) * (H - 2)));

        // Same ramp with sof and valid toggling; outputs must hold during gaps.
        base = n_win;
        for (int i = 0; i < W * H; i++) begin
            drive(8'(i + 40), 1'b1, i == 0);
            drive(8'hEE, 1'b0, 1'b0);
        end
        idle(3);
        check("gapped_count", 73'(n_win - base), 73'((W - 2) * (H - 2)));

        // Reset in mid-frame, then a fresh frame must not use stale line data.
        for (int i = 0; i < 7; i++) drive(8'(200 + i), 1'b1, i == 0);
        do_reset();
        base = n_win;
        for (int i = 0; i < W * H; i++) drive(8'(100 + i), 1'b1, 1'b0);
        idle(3);
        check("after_reset_count", 73'(n_win - base), 73'((W - 2) * (H - 2)));

        // sof reasserted mid-frame restarts the counters.
        for (int i = 0; i < 8; i++) drive(8'(150 + i), 1'b1, i == 0);
        base = n_win;
        for (int i = 0; i < W * H; i++) drive(8'(10 + i), 1'b1, i == 0);
        idle(3);
        check("resof_count", 73'(n_win - base), 73'((W - 2) * (H - 2)));

        // Randomized stream: random pixels, gaps, occasional sof anywhere.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0);
            if (i % 700 == 699) do_reset();
        end
        idle(4);
        check("queue_drained", 73'(exp_q.size()), 73'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
